i2c_target_core: RTL
====================

Name: i2c_target_core

Overview:
- I2C target (slave) byte engine: the other end of the team's single-master I2C master core.
- Samples the bus SCL/SDA with the system clock, detects START/STOP and matches a fixed 7-bit address.
- Receives write bytes to a user strobe interface; serves read bytes from a user handshake interface.
- Drives SDA open-drain via an output-enable (drive-low) signal; sits behind the Avalon slave wrapper's bus pins.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target ACKs.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection (minimum 2).

Ports:
- clk  in  1  system clock (must be at least 8x SCL rate)
- reset  in  1  asynchronous, active-high reset
- scl_i  in  1  bus SCL level
- sda_i  in  1  bus SDA level
- sda_oe  out  1  1 = pull SDA low; 0 = release
- scl_oe  out  1  1 = hold SCL low (clock stretch); constant 0 without CLK_STRETCH_EN
- rx_data  out  8  last byte written by the master
- rx_valid  out  1  one-cycle pulse; rx_data valid
- tx_data  in  8  next byte to return on a master read
- tx_valid  in  1  tx_data available
- tx_ready  out  1  one-cycle pulse; tx_data consumed this cycle
- start_det  out  1  one-cycle pulse on START or repeated START
- stop_det  out  1  one-cycle pulse on STOP
- busy  out  1  1 from an address match until STOP or a non-matching repeated START

Behaviour:
- Reset: all outputs 0, rx_data = 8'h00, state IDLE. Asserting reset mid-transfer releases SDA and SCL immediately (asynchronously).
- Inputs pass through SYNC_STAGES flops plus one history flop. scl_rise, scl_fall, sda_rise and sda_fall are single-cycle strobes.
- START = sda_fall while SCL high. STOP = sda_rise while SCL high.
  - Both take priority over data edges in any state.
  - START (from any state): pulse start_det, clear bit counter, go to ADDR, release sda_oe.
  - STOP (from any state): pulse stop_det, go to IDLE, release sda_oe, clear busy.
- Bit timing: data is sampled on scl_rise, MSB first. sda_oe changes only on scl_fall, or on START/STOP/reset.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match: on the next scl_fall assert sda_oe, set busy, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP with no ACK.
  - ADDR_ACK: on the following scl_fall release sda_oe. Then go to RX (W=0), or go to TX (R=1) and load the first byte.
  - RX: shift 8 bits. One cycle after the 8th scl_rise, rx_data is updated and rx_valid pulses. On the next scl_fall assert ACK, go to RX_ACK.
  - RX_ACK: on scl_fall release sda_oe, return to RX. Every received byte is ACKed; there is no backpressure on rx.
  - TX: drive sda_oe = ~shift[7] on each scl_fall, shift after each scl_rise. After 8 bits, release SDA on scl_fall and go to TX_ACK.
  - TX_ACK: sample master ACK on scl_rise.
    - ACK (SDA=0): go to TX and load the next byte.
    - NACK: go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Byte load (no stretch):
  - If tx_valid = 1: shift <= tx_data, tx_ready pulses in the same cycle.
  - Otherwise: shift <= 8'hFF, no tx_ready.
- Repeated START while busy: busy stays 1 until the new address phase completes; cleared on mismatch.
- Simultaneous scl_fall and STOP/START in one cycle: STOP/START wins.

Optional Feature:
- Macro: I2C_TARGET_CLK_STRETCH_EN.
- Defined:
  - At a TX byte load with tx_valid = 0, assert scl_oe (SCL held low) until tx_valid = 1. Then load the byte, pulse tx_ready, release scl_oe, and drive bit 7 in that same cycle.
  - STOP/START/reset releases scl_oe.
- Undefined: scl_oe tied 0; the 8'hFF fill rule applies.

Test Plan:
- Master writes addr 0x50 W, data 0xA5, 0x3C, STOP -> ACK on address and both bytes; rx_valid pulses twice with rx_data 0xA5 then 0x3C; stop_det pulses once; busy returns 0.
- Master addresses 0x51 W -> SDA never driven (sda_oe = 0 throughout); no rx_valid; busy stays 0; stop_det pulses at STOP.
- Master reads from 0x50 with tx_valid = 1 and tx_data 0x96 then 0x0F; master ACKs then NACKs -> bus bits 10010110, 00001111; two tx_ready pulses; WAIT_STOP after NACK.
- Write 0x50 W, 1 byte, repeated START, 0x50 R -> start_det pulses twice; busy held 1 across the repeated START; read phase entered.
- Read with tx_valid = 0 -> returns 0xFF with no tx_ready (stretch undefined); with I2C_TARGET_CLK_STRETCH_EN, scl_oe = 1 until tx_valid rises, then tx_data is returned.
- Assert reset mid-ACK (sda_oe = 1) -> sda_oe, scl_oe and busy drop to 0 without a clock edge; the next transfer works normally.

Source files
------------

// File: rtl/i2c_target_core.sv
// i2c_target_core: I2C target byte engine. Samples SCL/SDA with the system
// clock, detects START/STOP, matches TARGET_ADDR, then receives write bytes
// on rx_data/rx_valid and serves read bytes through tx_data/tx_valid/tx_ready.
// SDA is driven open-drain through sda_oe (1 = pull low).
// Optional clock stretching on a TX load with no data: I2C_TARGET_CLK_STRETCH_EN.
`timescale 1ns/1ps

module i2c_target_core #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic [7:0]             shift;
    logic [3:0]             bit_cnt;
    logic                   rw;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign sda_rise = sda_s & ~sda_d;
    assign sda_fall = ~sda_s & sda_d;
    // SCL history is used so a START/STOP coinciding with scl_fall still wins.
    assign start_cond = sda_fall & scl_d;
    assign stop_cond  = sda_rise & scl_d;

`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic scl_hold;
    logic stall;
    assign scl_oe = scl_hold;
`else
    logic [7:0] load_byte;
    assign scl_oe    = 1'b0;
    assign load_byte = tx_valid ? tx_data : 8'hFF;
`endif

    // Synchronise the bus lines; reset to the idle-high level to avoid false edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // Protocol FSM: bus conditions first, then per-state bit handling on SCL edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            busy      <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
            scl_hold  <= 1'b0;
            stall     <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            if (stop_cond) begin
                stop_det <= 1'b1;
                state    <= IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_hold <= 1'b0;
                stall    <= 1'b0;
`endif
            end else if (start_cond) begin
                start_det <= 1'b1;
                bit_cnt   <= '0;
                state     <= ADDR;
                sda_oe    <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_hold  <= 1'b0;
                stall     <= 1'b0;
            end else if (scl_hold) begin
                if (tx_valid) begin
                    shift    <= tx_data;
                    tx_ready <= 1'b1;
                    scl_hold <= 1'b0;
                    sda_oe   <= ~tx_data[7];
                end
`endif
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift[7:1] == TARGET_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shift[0];
                                state  <= ADDR_ACK;
                            end else begin
                                busy   <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                // First read byte is loaded and its MSB driven on the ACK's falling edge.
                                state <= TX;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                                if (tx_valid) begin
                                    shift    <= tx_data;
                                    tx_ready <= 1'b1;
                                    sda_oe   <= ~tx_data[7];
                                end else begin
                                    scl_hold <= 1'b1;
                                    sda_oe   <= 1'b0;
                                end
`else
                                shift    <= load_byte;
                                tx_ready <= tx_valid;
                                sda_oe   <= ~load_byte[7];
`endif
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= RX;
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {shift[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= RX_ACK;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= RX;
                        end
                    end
                    TX: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], 1'b1};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                            end else if (stall) begin
                                stall <= 1'b0;
                                if (tx_valid) begin
                                    shift    <= tx_data;
                                    tx_ready <= 1'b1;
                                    sda_oe   <= ~tx_data[7];
                                end else begin
                                    scl_hold <= 1'b1;
                                    sda_oe   <= 1'b0;
                                end
`endif
                            end else begin
                                sda_oe <= ~shift[7];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                state   <= TX;
                                bit_cnt <= '0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                                // Without data the stretch starts on the next falling edge, not while SCL is high.
                                if (tx_valid) begin
                                    shift    <= tx_data;
                                    tx_ready <= 1'b1;
                                end else begin
                                    stall <= 1'b1;
                                end
`else
                                shift    <= load_byte;
                                tx_ready <= tx_valid;
`endif
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: sda_oe <= 1'b0;
                    default:   state  <= IDLE;
                endcase
            end
        end
    end

endmodule
